pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline (F/D/E/M/W). Combines dbus wait,

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for the F/D/E/M/W pipeline. Merges dbus wait, ibus
//   wait, load-use hazards and execute-stage redirects into per-register
//   hold/bubble controls. A redirect resolved while an ifetch is still in
//   flight is parked in PEND and applied when that stale fetch returns, so the
//   wrong-path instruction can be discarded. Two saturating perf counters.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   ifetch_wait, dmem_wait     bus wait indications
//   de_ra1/2, de_use1/2        decode source registers and their use flags
//   ex_valid, ex_memread,
//   ex_dst                     execute instruction / load / destination
//   ex_redirect, ex_target     execute-resolved redirect and its target pc
//   stall_f/d/e/m              hold PC / F-D / D-E / E-M
//   flush_d, flush_e, bubble_w bubble into F-D / D-E / M-W
//   pc_redirect, pc_target     PC load (overrides stall_f), target (0 if idle)
//   drop_fetch                 discard the instruction fetched this cycle
//   stall_cnt, redir_cnt       saturating perf counters
module pipe_hazard_ctrl #(
  parameter int ADDR_W = 64,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ifetch_wait,
  input  logic              dmem_wait,
  input  logic [REG_W-1:0]  de_ra1,
  input  logic [REG_W-1:0]  de_ra2,
  input  logic              de_use1,
  input  logic              de_use2,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_W-1:0]  ex_dst,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              bubble_w,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              drop_fetch,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  redir_cnt
);

  typedef enum logic {ST_RUN, ST_PEND} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    redir_cnt_q, redir_cnt_d;
  logic                load_use, redirect;

  // x0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = ex_valid & ex_memread & (ex_dst != '0) &
                    ((de_use1 & (de_ra1 == ex_dst)) | (de_use2 & (de_ra2 == ex_dst)));
  // While the dbus waits the E register is held, so the redirect is simply
  // seen again once the wait ends.
  assign redirect = ex_valid & ex_redirect & ~dmem_wait;

  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    bubble_w    = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    drop_fetch  = 1'b0;
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;

    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (dmem_wait) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
          end else if (redirect) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            if (!ifetch_wait) begin
              pc_redirect = 1'b1;
              pc_target   = ex_target;
            end else begin
              // Fetch in flight: its return is wrong-path, park the target.
              stall_f   = 1'b1;
              pend_pc_d = ex_target;
              state_d   = ST_PEND;
            end
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else if (ifetch_wait) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
          end
        end
        ST_PEND: begin
          flush_d = 1'b1;
          // Pending redirect completes regardless of dmem_wait; the memory
          // stall still applies to the back end this cycle.
          if (dmem_wait) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
          end
          if (ifetch_wait) begin
            stall_f = 1'b1;
          end else begin
            drop_fetch  = 1'b1;
            pc_redirect = 1'b1;
            pc_target   = pend_pc_q;
            state_d     = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end

    stall_cnt_d = stall_cnt_q;
    if ((stall_d | flush_d) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    redir_cnt_d = redir_cnt_q;
    if (pc_redirect && (redir_cnt_q != '1))
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pend_pc_q   <= '0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign redir_cnt = redir_cnt_q;

endmodule
